// File: rtl/bcd_scan_display.sv
// ============================================================================
// Module  : bcd_scan_display
// Brief   : Multiplexed seven-segment driver with load snapshot, leading-zero
//           blanking and non-BCD detection. Falling-edge clocked.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_en,
  output logic                  err
);

  localparam int P_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int I_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [P_W-1:0] P_LAST = P_W'(SCAN_DIV - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] snap;
  logic [P_W-1:0]      p;
  logic [I_W-1:0]      idx;

  logic [3:0]          cur;
  logic [DIGITS-1:0]   lz;
  logic [DIGITS-1:0]   en_next;
  logic [6:0]          seg_next;
  logic                err_next;
  logic                higher_zero;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'b1111110;
      4'd1:    dec = 7'b0110000;
      4'd2:    dec = 7'b1101101;
      4'd3:    dec = 7'b1111001;
      4'd4:    dec = 7'b0110011;
      4'd5:    dec = 7'b1011011;
      4'd6:    dec = 7'b1011111;
      4'd7:    dec = 7'b1110000;
      4'd8:    dec = 7'b1111111;
      4'd9:    dec = 7'b1111011;
      default: dec = 7'b0000001;
    endcase
  endfunction

  always_comb begin
    cur         = 4'd0;
    en_next     = '0;
    lz          = '0;
    higher_zero = 1'b1;
    err_next    = 1'b0;
    seg_next    = 7'd0;
    // lz[i] is set when digit i and every more significant digit are zero
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (snap[4*i +: 4] == 4'd0);
      lz[i]       = higher_zero;
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == I_W'(i)) begin
        cur        = snap[4*i +: 4];
        en_next[i] = 1'b1;
      end
      if (bcd_in[4*i +: 4] > 4'd9) err_next = 1'b1;
    end
    seg_next = dec(cur);
    if (p == '0) begin
      en_next  = '0;
      seg_next = 7'd0;
    end else if ((BLANK_LZ != 0) && (idx != '0) && (|(lz & en_next))) begin
      seg_next = 7'd0;
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      snap   <= '0;
      p      <= '0;
      idx    <= '0;
      seg    <= 7'd0;
      dig_en <= '0;
      err    <= 1'b0;
    end else begin
      seg    <= seg_next;
      dig_en <= en_next;
      if (load) begin
        snap <= bcd_in;
        err  <= err_next;
      end
      if (p == P_LAST) begin
        p   <= '0;
        idx <= (idx == I_LAST) ? '0 : idx + I_W'(1);
      end else begin
        p <= p + P_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
